// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared constants for the frame-buffer port-A write arbiter.
// Requester indices, one-hot grant codes and the rejected-write counter limit.
package bram_arb_pkg;

   // Requester indices, also used as values of the round-robin pointer
   localparam logic REQ_PAT = 1'b0;   // pattern generator
   localparam logic REQ_COM = 1'b1;   // UART command-to-memory loader

   // One-hot owner codes driven on o_grant
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_PAT  = 2'b01;
   localparam logic [1:0] GNT_COM  = 2'b10;

   // Default width and saturation value of the rejected-write counter
   localparam int             ERR_W   = 8;
   localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};

endpackage

// File: rtl/wr_slot.sv
// wr_slot: one-entry holding register (address + data) with a full flag.
// A load on the same cycle as a clear refills the slot, so a granted
// requester can hand over its next word without a bubble.
module wr_slot #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_clear,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_full,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_full;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   // Occupancy flag: load has priority over clear so refill-on-grant keeps it set
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   // Payload capture; contents are meaningless while the slot is empty
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_addr <= i_addr;
         r_data <= i_data;
      end
   end

   assign o_full = r_full;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/bram_wr_arbiter.sv
// bram_wr_arbiter: shares BRAM port A between the pattern generator (req 0)
// and the UART loader (req 1). Each requester owns a one-entry slot; one
// write per enabled cycle is scheduled round-robin, or only req 1 in lock
// mode, and presented on a registered port-A bus. Out-of-range addresses are
// dropped at accept time and counted in a saturating error counter.
// Optional: define BRAM_WR_ARB_STATS_EN to add per-requester grant counters
// o_cnt0/o_cnt1 for the debug display.
module bram_wr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 76_800,
   parameter int ERR_WIDTH  = ERR_W
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_lock,
   input  logic                  i_wr0,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [DATA_WIDTH-1:0] i_data0,
   output logic                  o_rdy0,
   input  logic                  i_wr1,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_data1,
   output logic                  o_rdy1,
   output logic                  o_wea,
   output logic [ADDR_WIDTH-1:0] o_addra,
   output logic [DATA_WIDTH-1:0] o_dia,
   output logic [1:0]            o_grant,
   output logic [ERR_WIDTH-1:0]  o_err_cnt
`ifdef BRAM_WR_ARB_STATS_EN
   ,
   output logic [15:0]           o_cnt0,
   output logic [15:0]           o_cnt1
`endif
);

   localparam logic [ERR_WIDTH-1:0] L_ERR_MAX =
      (ERR_WIDTH == ERR_W) ? ERR_WIDTH'(ERR_SAT) : {ERR_WIDTH{1'b1}};

   // Saturating add of up to two rejections per cycle
   function automatic logic [ERR_WIDTH-1:0] err_sat_add(
      input logic [ERR_WIDTH-1:0] a,
      input logic [1:0]           b
   );
      logic [ERR_WIDTH:0] s;
      s = {1'b0, a} + (ERR_WIDTH+1)'(b);
      return s[ERR_WIDTH] ? L_ERR_MAX : s[ERR_WIDTH-1:0];
   endfunction

   logic                  w_full0, w_full1;
   logic [ADDR_WIDTH-1:0] w_saddr0, w_saddr1;
   logic [DATA_WIDTH-1:0] w_sdata0, w_sdata1;
   logic                  w_elig0, w_elig1, w_both;
   logic [1:0]            w_gnt;
   logic                  w_acc0, w_acc1, w_inr0, w_inr1;
   logic                  w_load0, w_load1, w_rej0, w_rej1;

   logic                  r_rr_ptr;
   logic                  r_wea;
   logic [ADDR_WIDTH-1:0] r_addra;
   logic [DATA_WIDTH-1:0] r_dia;
   logic [1:0]            r_grant;
   logic [ERR_WIDTH-1:0]  r_err_cnt;

   // Requester 0 is masked by lock in the same cycle the lock changes
   assign w_elig0 = i_enable & w_full0 & ~i_lock;
   assign w_elig1 = i_enable & w_full1;
   assign w_both  = w_elig0 & w_elig1;

   // Scheduler: single eligible wins; on contention the side not named by the pointer wins
   always_comb begin
      w_gnt = GNT_NONE;
      if (w_both) begin
         w_gnt = (r_rr_ptr == REQ_PAT) ? GNT_COM : GNT_PAT;
      end else if (w_elig0) begin
         w_gnt = GNT_PAT;
      end else if (w_elig1) begin
         w_gnt = GNT_COM;
      end
   end

   // A slot can take a new word if empty or being drained this cycle
   assign o_rdy0 = ~w_full0 | w_gnt[REQ_PAT];
   assign o_rdy1 = ~w_full1 | w_gnt[REQ_COM];

   assign w_acc0  = i_wr0 & o_rdy0;
   assign w_acc1  = i_wr1 & o_rdy1;
   assign w_inr0  = (32'(i_addr0) < 32'(DEPTH));
   assign w_inr1  = (32'(i_addr1) < 32'(DEPTH));
   assign w_load0 = w_acc0 & w_inr0;
   assign w_load1 = w_acc1 & w_inr1;
   assign w_rej0  = w_acc0 & ~w_inr0;
   assign w_rej1  = w_acc1 & ~w_inr1;

   wr_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot0 (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load0),
      .i_clear (w_gnt[REQ_PAT]),
      .i_addr  (i_addr0),
      .i_data  (i_data0),
      .o_full  (w_full0),
      .o_addr  (w_saddr0),
      .o_data  (w_sdata0)
   );

   wr_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot1 (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load1),
      .i_clear (w_gnt[REQ_COM]),
      .i_addr  (i_addr1),
      .i_data  (i_data1),
      .o_full  (w_full1),
      .o_addr  (w_saddr1),
      .o_data  (w_sdata1)
   );

   // Round-robin pointer remembers the winner of the last contended cycle
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr <= REQ_PAT;
      end else if (w_both) begin
         r_rr_ptr <= w_gnt[REQ_COM] ? REQ_COM : REQ_PAT;
      end
   end

   // Registered port-A bus; address/data hold their last value when idle
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wea   <= 1'b0;
         r_grant <= GNT_NONE;
         r_addra <= '0;
         r_dia   <= '0;
      end else begin
         r_wea   <= (w_gnt != GNT_NONE);
         r_grant <= w_gnt;
         if (w_gnt[REQ_COM]) begin
            r_addra <= w_saddr1;
            r_dia   <= w_sdata1;
         end else if (w_gnt[REQ_PAT]) begin
            r_addra <= w_saddr0;
            r_dia   <= w_sdata0;
         end
      end
   end

   // Rejected-write counter, both requesters may be rejected in one cycle
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_cnt <= '0;
      end else if (w_rej0 | w_rej1) begin
         r_err_cnt <= err_sat_add(r_err_cnt, {1'b0, w_rej0} + {1'b0, w_rej1});
      end
   end

   assign o_wea     = r_wea;
   assign o_addra   = r_addra;
   assign o_dia     = r_dia;
   assign o_grant   = r_grant;
   assign o_err_cnt = r_err_cnt;

`ifdef BRAM_WR_ARB_STATS_EN
   logic [15:0] r_cnt0, r_cnt1;

   // Per-requester granted-write counters, saturating for the debug display
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_gnt[REQ_PAT] && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
         if (w_gnt[REQ_COM] && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
      end
   end

   assign o_cnt0 = r_cnt0;
   assign o_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// tb_bram_wr_arbiter: table-driven, directed and random checks of the
// BRAM port-A write arbiter against a queue-style reference model.
module tb_bram_wr_arbiter;

   localparam int AW      = 17;
   localparam int DW      = 12;
   localparam int DEPTH   = 76_800;
   localparam int EW      = 8;
   localparam int ERR_MAX = 255;

   logic          clk = 1'b0;
   logic          i_rst_n = 1'b1;
   logic          i_enable, i_lock, i_wr0, i_wr1;
   logic [AW-1:0] i_addr0, i_addr1;
   logic [DW-1:0] i_data0, i_data1;
   logic          o_rdy0, o_rdy1, o_wea;
   logic [AW-1:0] o_addra;
   logic [DW-1:0] o_dia;
   logic [1:0]    o_grant;
   logic [EW-1:0] o_err_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bram_wr_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ERR_WIDTH(EW)
   ) dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_lock(i_lock),
      .i_wr0(i_wr0), .i_addr0(i_addr0), .i_data0(i_data0), .o_rdy0(o_rdy0),
      .i_wr1(i_wr1), .i_addr1(i_addr1), .i_data1(i_data1), .o_rdy1(o_rdy1),
      .o_wea(o_wea), .o_addra(o_addra), .o_dia(o_dia), .o_grant(o_grant),
      .o_err_cnt(o_err_cnt)
   );

   typedef struct {
      int en, lk, w0, a0, d0, w1, a1, d1;
      int r0, r1, wea, addr, dat, gnt, err;
   } vec_t;

   // Current cycle's stimulus as plain integers
   int c_en, c_lk, c_w0, c_a0, c_d0, c_w1, c_a1, c_d1;
   // Sampled ready flags of the last applied cycle
   int g_s0, g_s1;
   // Reference model: two pending-write slots, last contention winner, bus image
   int m_full[2];
   int m_saddr[2];
   int m_sdata[2];
   int m_last;
   int m_err, m_wea, m_oaddr, m_odata, m_ogrant;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_full[i] = 0; m_saddr[i] = 0; m_sdata[i] = 0;
      end
      m_last = 0; m_err = 0; m_wea = 0; m_oaddr = 0; m_odata = 0; m_ogrant = 0;
   endtask

   // Which requester writes this cycle: -1 none, 0 or 1
   function automatic int m_pick();
      int e0, e1;
      e0 = (c_en != 0 && m_full[0] != 0 && c_lk == 0) ? 1 : 0;
      e1 = (c_en != 0 && m_full[1] != 0) ? 1 : 0;
      if (e0 != 0 && e1 != 0) return 1 - m_last;
      if (e0 != 0) return 0;
      if (e1 != 0) return 1;
      return -1;
   endfunction

   function automatic int m_rdy(input int n);
      return (m_full[n] == 0 || m_pick() == n) ? 1 : 0;
   endfunction

   task automatic m_step();
      int g, r0, r1, both, rej;
      g    = m_pick();
      r0   = m_rdy(0);
      r1   = m_rdy(1);
      rej  = 0;
      both = (c_en != 0 && m_full[0] != 0 && c_lk == 0 && m_full[1] != 0) ? 1 : 0;
      if (both != 0) m_last = g;
      if (g >= 0) begin
         m_wea = 1; m_oaddr = m_saddr[g]; m_odata = m_sdata[g];
         m_ogrant = 1 << g; m_full[g] = 0;
      end else begin
         m_wea = 0; m_ogrant = 0;
      end
      if (c_w0 != 0 && r0 != 0) begin
         if (c_a0 < DEPTH) begin m_full[0] = 1; m_saddr[0] = c_a0; m_sdata[0] = c_d0; end
         else rej++;
      end
      if (c_w1 != 0 && r1 != 0) begin
         if (c_a1 < DEPTH) begin m_full[1] = 1; m_saddr[1] = c_a1; m_sdata[1] = c_d1; end
         else rej++;
      end
      m_err = (m_err + rej > ERR_MAX) ? ERR_MAX : m_err + rej;
   endtask

   // One clock: drive, check ready, clock, check registered outputs against the model
   task automatic cyc(input int en, lk, w0, a0, d0, w1, a1, d1);
      c_en = en; c_lk = lk; c_w0 = w0; c_a0 = a0; c_d0 = d0;
      c_w1 = w1; c_a1 = a1; c_d1 = d1;
      i_enable = (en != 0); i_lock = (lk != 0);
      i_wr0 = (w0 != 0); i_addr0 = AW'(a0); i_data0 = DW'(d0);
      i_wr1 = (w1 != 0); i_addr1 = AW'(a1); i_data1 = DW'(d1);
      #1;
      g_s0 = o_rdy0 ? 1 : 0;
      g_s1 = o_rdy1 ? 1 : 0;
      chk("rdy0", 32'(o_rdy0), m_rdy(0));
      chk("rdy1", 32'(o_rdy1), m_rdy(1));
      @(posedge clk);
      m_step();
      #1;
      chk("wea",   32'(o_wea),     m_wea);
      chk("grant", 32'(o_grant),   m_ogrant);
      chk("addra", 32'(o_addra),   m_oaddr);
      chk("dia",   32'(o_dia),     m_odata);
      chk("err",   32'(o_err_cnt), m_err);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_enable = 1'b0; i_lock = 1'b0; i_wr0 = 1'b0; i_wr1 = 1'b0;
      i_addr0 = '0; i_addr1 = '0; i_data0 = '0; i_data1 = '0;
      #1;
      chk("rst_wea",   32'(o_wea),     0);
      chk("rst_addra", 32'(o_addra),   0);
      chk("rst_dia",   32'(o_dia),     0);
      chk("rst_grant", 32'(o_grant),   0);
      chk("rst_err",   32'(o_err_cnt), 0);
      chk("rst_rdy0",  32'(o_rdy0),    1);
      chk("rst_rdy1",  32'(o_rdy1),    1);
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 15) == 0) return DEPTH + int'($urandom_range(0, 600));
      return int'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t reached limit 1000000 without summary", $time);
      $fatal(1);
   end

   initial begin
      vec_t tbl[13];
      int w0, w1, n0, n1, p0, p1, np, prev, cnt;

      //           en lk w0 a0     d0     w1 a1      d1      r0 r1 wea addr dat    gnt err
      tbl[0]  = '{1, 0, 1, 5,     'hABC, 0, 0,      0,      1, 1, 0,  0,   0,     0,  0};
      tbl[1]  = '{1, 0, 1, 10,    'h111, 0, 0,      0,      1, 1, 1,  5,   'hABC, 1,  0};
      tbl[2]  = '{1, 0, 1, 11,    'h222, 0, 0,      0,      1, 1, 1,  10,  'h111, 1,  0};
      tbl[3]  = '{1, 0, 0, 0,     0,     0, 0,      0,      1, 1, 1,  11,  'h222, 1,  0};
      tbl[4]  = '{1, 0, 0, 0,     0,     0, 0,      0,      1, 1, 0,  11,  'h222, 0,  0};
      tbl[5]  = '{1, 0, 0, 0,     0,     1, 76800,  0,      1, 1, 0,  11,  'h222, 0,  1};
      tbl[6]  = '{1, 0, 1, 20,    'h020, 1, 30,     'h030,  1, 1, 0,  11,  'h222, 0,  1};
      tbl[7]  = '{1, 0, 0, 0,     0,     0, 0,      0,      0, 1, 1,  30,  'h030, 2,  1};
      tbl[8]  = '{1, 0, 0, 0,     0,     0, 0,      0,      1, 1, 1,  20,  'h020, 1,  1};
      tbl[9]  = '{1, 0, 1, 76800, 0,     1, 131071, 0,      1, 1, 0,  20,  'h020, 0,  3};
      tbl[10] = '{0, 0, 1, 40,    'h040, 0, 0,      0,      1, 1, 0,  20,  'h020, 0,  3};
      tbl[11] = '{0, 0, 0, 0,     0,     0, 0,      0,      0, 1, 0,  20,  'h020, 0,  3};
      tbl[12] = '{1, 0, 0, 0,     0,     0, 0,      0,      1, 1, 1,  40,  'h040, 1,  3};

      m_reset();
      do_reset();

      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].en, tbl[i].lk, tbl[i].w0, tbl[i].a0, tbl[i].d0,
             tbl[i].w1, tbl[i].a1, tbl[i].d1);
         chk($sformatf("tbl%0d_rdy0", i),  g_s0,               tbl[i].r0);
         chk($sformatf("tbl%0d_rdy1", i),  g_s1,               tbl[i].r1);
         chk($sformatf("tbl%0d_wea", i),   32'(o_wea),         tbl[i].wea);
         chk($sformatf("tbl%0d_addra", i), 32'(o_addra),       tbl[i].addr);
         chk($sformatf("tbl%0d_dia", i),   32'(o_dia),         tbl[i].dat);
         chk($sformatf("tbl%0d_grant", i), 32'(o_grant),       tbl[i].gnt);
         chk($sformatf("tbl%0d_err", i),   32'(o_err_cnt),     tbl[i].err);
      end

      // Both requesters strobe every cycle from a fresh pointer
      do_reset();
      n0 = 0; n1 = 0; w0 = 0; w1 = 0; p0 = 0; p1 = 0; np = 0; prev = 1;
      for (int c = 0; c < 104; c++) begin
         if (c < 100) cyc(1, 0, 1, 1000 + n0, n0 % 4096, 1, 2000 + n1, (n1 + 7) % 4096);
         else         cyc(1, 0, 0, 0, 0, 0, 0, 0);
         if (c < 100) begin
            if (g_s0 != 0) n0++;
            if (g_s1 != 0) n1++;
         end
         if (o_wea) begin
            if (o_grant == 2'b01) begin
               chk("alt_addr0", 32'(o_addra), 1000 + w0); w0++;
               if (np < 100) p0++;
            end else begin
               chk("alt_addr1", 32'(o_addra), 2000 + w1); w1++;
               if (np < 100) p1++;
            end
            chk("alt_order", 32'(o_grant), (prev == 1) ? 2 : 1);
            prev = (o_grant == 2'b01) ? 1 : 2;
            np++;
         end
      end
      chk("alt_share_pat", p0, 50);
      chk("alt_share_com", p1, 50);
      chk("alt_nolost0",   w0, n0);
      chk("alt_nolost1",   w1, n1);

      // Lock mode holds a loaded requester-0 word until lock drops
      cyc(0, 0, 1, 7, 'h777, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) cyc(1, 1, 0, 0, 0, 1, i, 'h100 + i);
         else       cyc(1, 1, 0, 0, 0, 0, 0, 0);
         chk("lock_rdy0", g_s0, 0);
         if (o_wea) begin
            chk("lock_owner", 32'(o_grant), 2);
            cnt++;
         end
      end
      chk("lock_grants", cnt, 4);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("unlock_wea",   32'(o_wea),   1);
      chk("unlock_addr",  32'(o_addra), 7);
      chk("unlock_data",  32'(o_dia),   'h777);
      chk("unlock_grant", 32'(o_grant), 1);

      // Enable low freezes both full slots; one enabled cycle gives one grant
      cyc(0, 0, 1, 50, 'h050, 1, 60, 'h060);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0);
         chk("en0_wea",  32'(o_wea), 0);
         chk("en0_rdy0", g_s0, 0);
         chk("en0_rdy1", g_s1, 0);
      end
      cnt = 0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0); if (o_wea) cnt++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0); if (o_wea) cnt++;
      cyc(0, 0, 0, 0, 0, 0, 0, 0); if (o_wea) cnt++;
      chk("en_one_grant", cnt, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // Error counter saturation
      for (int i = 0; i < 300; i++) cyc(1, 0, 0, 0, 0, 1, DEPTH, 0);
      chk("err_sat", 32'(o_err_cnt), ERR_MAX);

      // Reset with both slots full discards them
      cyc(0, 0, 1, 70, 'h070, 1, 80, 'h080);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_wea", 32'(o_wea), 1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0);
         chk("no_stale_wea", 32'(o_wea), 0);
      end
      cyc(1, 0, 1, 90, 'h090, 0, 0, 0);
      chk("post_rst_lat1", 32'(o_wea), 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_wea",   32'(o_wea),   1);
      chk("post_rst_addr",  32'(o_addra), 90);
      chk("post_rst_grant", 32'(o_grant), 1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) != 0) ? 1 : 0,
             ($urandom_range(0, 7) == 0) ? 1 : 0,
             int'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(0, 4095)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_wr_arbiter.md
Name: bram_wr_arbiter

Overview:
Shares frame-buffer BRAM port A between two writers: requester 0 (pattern generator) and requester 1 (UART command-to-memory loader). Each requester has a one-entry holding slot and a ready flag. A round-robin or lock-mode scheduler issues at most one write per clock onto the registered port-A bus. Out-of-range addresses are rejected and counted, never written.

Parameters:
ADDR_WIDTH, 17, BRAM address width
DATA_WIDTH, 12, pixel word width (RGB444)
DEPTH, 76_800, valid addresses 0..DEPTH-1
ERR_WIDTH, 8, width of rejected-write counter

Ports:
clk  in  1  system clock (100 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  clock-enable tick; port A is driven only on enabled cycles
i_lock  in  1  1 = only requester 1 may be granted (UART load mode, sw[0])
i_wr0  in  1  requester 0 write strobe
i_addr0  in  ADDR_WIDTH  requester 0 address
i_data0  in  DATA_WIDTH  requester 0 data
o_rdy0  out  1  requester 0 slot can accept this cycle
i_wr1  in  1  requester 1 write strobe
i_addr1  in  ADDR_WIDTH  requester 1 address
i_data1  in  DATA_WIDTH  requester 1 data
o_rdy1  out  1  requester 1 slot can accept this cycle
o_wea  out  1  BRAM port A write enable
o_addra  out  ADDR_WIDTH  BRAM port A address
o_dia  out  DATA_WIDTH  BRAM port A data
o_grant  out  2  one-hot owner of the current o_wea pulse
o_err_cnt  out  ERR_WIDTH  saturating count of rejected out-of-range writes

Behaviour:
- Reset (async assert, sync release): both slots empty, o_wea=0, o_addra=0, o_dia=0, o_grant=00, o_err_cnt=0, RR pointer = requester 0. Reset mid-operation discards pending slots without a write.
- Accept: i_wrN && o_rdyN loads slot N in the next cycle. i_wrN while o_rdyN=0 is a protocol violation; the write is ignored and the slot is unchanged.
- o_rdyN = slot N empty OR slot N is granted this cycle. Allows one write per cycle per requester when uncontended.
- Range check at accept: addr >= DEPTH is not loaded. o_err_cnt increments by one and saturates at all-ones. When both requesters are rejected in the same cycle, the count increases by 2, saturating.
- Schedule (evaluated only when i_enable=1): eligible = slot full, and for requester 0 also !i_lock.
  - One eligible: that requester is granted.
  - Both eligible: the requester not named by the RR pointer is granted. The pointer then records the winner.
- Grant outputs: registered. Cycle after grant, o_wea=1, o_addra/o_dia = slot contents, o_grant one-hot; the slot empties on the grant cycle. Latency from accepted strobe to o_wea is 2 cycles minimum.
- With no grant, o_wea=0 and o_grant=00. o_addra/o_dia hold their last values.
- i_enable=0: no grant, slots hold, o_wea=0 in the following cycle.
- Lock asserted with slot 0 full: slot 0 is held, not dropped, and o_rdy0=0. It drains once i_lock falls.
- A lock change takes effect in the same cycle's scheduling decision.

Optional Feature:
Macro BRAM_WR_ARB_STATS_EN.
- Defined: adds outputs o_cnt0 and o_cnt1, each 16 bits. Each counts granted writes per requester, saturating at 16'hFFFF, reset to 0, for the 7-segment debug display.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package bram_arb_pkg holds:
  - requester index constants REQ_PAT=0 and REQ_COM=1
  - grant one-hot localparams GNT_NONE, GNT_PAT, GNT_COM
  - the ERR counter saturation value
- Natural sub-module: wr_slot, a one-entry holding register with full flag, load and clear, instantiated twice.

Test Plan:
- Requester 0 only, i_enable=1: write addr 5 data 12'hABC → o_wea=1, o_addra=5, o_dia=ABC, o_grant=01 two cycles after strobe. o_rdy0 stays 1 on back-to-back strobes.
- Both strobing every cycle, RR pointer at reset → grants alternate 10,01,10,01…; each requester gets exactly 50% over 100 cycles and nothing is lost.
- i_lock=1 with slot 0 loaded (addr 7) and requester 1 writing addrs 0..3 → only 10 grants and o_rdy0=0. Drop i_lock → addr 7 is written next.
- Requester 1 writes addr 76_800 → no o_wea, o_err_cnt=1. 300 such writes → o_err_cnt saturates at 255.
- i_enable held 0 with both slots full → o_wea stays 0 and the slots are retained. Enable for one cycle → exactly one grant.
- Assert i_rst_n=0 while both slots are full → outputs clear immediately. After release there is no stale write, and the first new strobe is granted normally.
